// File: rtl/cc_apb_bridge.sv
`timescale 1ns/1ps
// XBAR slave-port responder that replays one req/gnt transaction at a time as an APB4
// master transfer, with a local address-window check and a PREADY timeout.
module cc_apb_bridge #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   APB_BASE = 32'h0600_0000,
  parameter logic [AW-1:0]   APB_END  = 32'h0800_0000,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o,
  output logic [AW-1:0]   paddr_o,
  output logic            psel_o,
  output logic            penable_o,
  output logic            pwrite_o,
  output logic [DW-1:0]   pwdata_o,
  output logic [DW/8-1:0] pstrb_o,
  input  logic            pready_i,
  input  logic [DW-1:0]   prdata_i,
  input  logic            pslverr_i
);

  localparam int              CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [AW-1:0]   WORD_MASK = ~(AW'(3));

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [AW-1:0]     r_paddr;
  logic [DW-1:0]     r_pwdata;
  logic [DW/8-1:0]   r_pstrb;
  logic              r_rvalid;
  logic [DW-1:0]     r_rdata;
  logic              r_err;

  logic              w_gnt;
  logic              w_in_range;
  logic [AW-1:0]     w_offset;

  assign w_in_range = (addr_i >= APB_BASE) && (addr_i < APB_END);
  assign w_offset   = (addr_i - APB_BASE) & WORD_MASK;
  assign w_gnt      = req_i && (r_state == S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            if (w_in_range) begin
              // Read transfers carry no data or strobes on the APB side.
              r_state  <= S_SETUP;
              r_psel   <= 1'b1;
              r_paddr  <= w_offset;
              r_pwrite <= we_i;
              r_pwdata <= we_i ? wdata_i : '0;
              r_pstrb  <= we_i ? be_i : '0;
            end else begin
              r_state  <= S_ERR;
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_rdata  <= '0;
            end
          end
        end

        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end

        S_ACCESS: begin
          if (pready_i) begin
            r_state   <= S_RESP;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_rvalid  <= 1'b1;
            r_err     <= pslverr_i;
            r_rdata   <= r_pwrite ? '0 : prdata_i;
          end else if (r_cnt == CNT_LAST) begin
            // Peripheral never answered: abandon the transfer and report an error.
            r_state   <= S_RESP;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_rvalid  <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_RESP, S_ERR: begin
          r_state  <= S_IDLE;
          r_rvalid <= 1'b0;
          r_err    <= 1'b0;
          r_rdata  <= '0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_cnt     <= '0;
          r_rvalid  <= 1'b0;
          r_err     <= 1'b0;
          r_rdata   <= '0;
        end
      endcase
    end
  end

  assign gnt_o     = w_gnt;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;
  assign paddr_o   = r_paddr;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwrite_o  = r_pwrite;
  assign pwdata_o  = r_pwdata;
  assign pstrb_o   = r_pstrb;

endmodule

// File: tb/tb_cc_apb_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for cc_apb_bridge: directed scenarios plus randomized transactions,
// each checked cycle by cycle against a timing/response model derived from the window and timeout rules.
module tb_cc_apb_bridge;

  localparam logic [31:0] BASE = 32'h0600_0000;
  localparam logic [31:0] ENDA = 32'h0800_0000;
  localparam int          TO   = 16;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;   // wait states before pready; >= TO means the peripheral never answers
    logic        slverr;
    logic [31:0] prdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cc_apb_bridge #(
    .AW(32), .DW(32), .APB_BASE(BASE), .APB_END(ENDA), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d, input int ws, input logic se,
                              input logic [31:0] rd);
    txn_t t;
    t.addr = a; t.we = w; t.be = b; t.wdata = d; t.waits = ws; t.slverr = se; t.prdata = rd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0, 1, 2, 3: t.addr = BASE + ($urandom % (ENDA - BASE));
      4:          t.addr = BASE - 32'd1 - ($urandom % 8);
      5:          t.addr = ENDA + ($urandom % 8);
      6:          t.addr = ENDA - 32'd1 - ($urandom % 8);
      default:    t.addr = $urandom;
    endcase
    t.we = $urandom_range(0, 1) == 1;
    t.be = 4'($urandom);
    t.wdata = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6)       t.waits = $urandom_range(0, 3);
    else if (k < 8)  t.waits = $urandom_range(4, 8);
    else if (k == 8) t.waits = TO - 1;
    else             t.waits = TO + $urandom_range(0, 2);
    t.slverr = $urandom_range(0, 3) == 0;
    t.prdata = $urandom;
    return t;
  endfunction

  // Drives one transaction and checks every output on every cycle from grant (cycle 0)
  // until the response (plus three idle cycles, unless the next request is chained).
  task automatic do_txn(input txn_t t, input bit chained_in, input bit chain_out, input txn_t nx);
    bit          oor, to_hit;
    int          r, last;
    bit          e_psel, e_pen, e_rv;
    logic [31:0] e_paddr, e_pwdata, e_rdata;
    logic [3:0]  e_pstrb;
    logic        e_err;
    oor     = !(t.addr >= BASE && t.addr < ENDA);
    to_hit  = !oor && (t.waits >= TO);
    r       = oor ? 1 : (to_hit ? 2 + TO : 3 + t.waits);
    e_paddr = ((t.addr - BASE) / 4) * 4;
    e_pwdata = t.we ? t.wdata : 32'h0;
    e_pstrb  = t.we ? t.be : 4'h0;
    e_err    = oor || to_hit || t.slverr;
    e_rdata  = (oor || to_hit || t.we) ? 32'h0 : t.prdata;

    if (chained_in) begin
      @(negedge clk);
    end else begin
      req = 1'b1; addr = t.addr; we = t.we; be = t.be; wdata = t.wdata;
    end
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin n_err++; $display("FAIL gnt_c0 addr=%h: got %b expected 1", t.addr, gnt); end

    last = chain_out ? r : r + 3;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      e_psel = !oor && (c < r);
      e_pen  = !oor && (c >= 2) && (c < r);
      e_rv   = (c == r);
      n_cmp++;
      if (psel !== e_psel) begin n_err++; $display("FAIL psel c%0d addr=%h: got %b expected %b", c, t.addr, psel, e_psel); end
      n_cmp++;
      if (penable !== e_pen) begin n_err++; $display("FAIL penable c%0d addr=%h: got %b expected %b", c, t.addr, penable, e_pen); end
      n_cmp++;
      if (rvalid !== e_rv) begin n_err++; $display("FAIL rvalid c%0d addr=%h: got %b expected %b", c, t.addr, rvalid, e_rv); end
      n_cmp++;
      if (err !== (e_rv ? e_err : 1'b0)) begin
        n_err++; $display("FAIL err c%0d addr=%h: got %b expected %b", c, t.addr, err, e_rv ? e_err : 1'b0);
      end
      n_cmp++;
      if (rdata !== (e_rv ? e_rdata : 32'h0)) begin
        n_err++; $display("FAIL rdata c%0d addr=%h: got %h expected %h", c, t.addr, rdata, e_rv ? e_rdata : 32'h0);
      end
      if (e_psel) begin
        n_cmp++;
        if (paddr !== e_paddr) begin n_err++; $display("FAIL paddr c%0d: got %h expected %h", c, paddr, e_paddr); end
        n_cmp++;
        if (pwrite !== t.we) begin n_err++; $display("FAIL pwrite c%0d: got %b expected %b", c, pwrite, t.we); end
        n_cmp++;
        if (pwdata !== e_pwdata) begin n_err++; $display("FAIL pwdata c%0d: got %h expected %h", c, pwdata, e_pwdata); end
        n_cmp++;
        if (pstrb !== e_pstrb) begin n_err++; $display("FAIL pstrb c%0d: got %h expected %h", c, pstrb, e_pstrb); end
      end
      // Peripheral side: answer after the requested wait states; after a timeout, send a late pulse.
      if (!oor && !to_hit && c == 2 + t.waits) begin
        pready = 1'b1; prdata = t.prdata; pslverr = t.slverr;
      end else if (to_hit && (c == r + 1 || c == r + 2)) begin
        pready = 1'b1; prdata = $urandom; pslverr = 1'($urandom);
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      if (chain_out && c == r) begin
        req = 1'b1; addr = nx.addr; we = nx.we; be = nx.be; wdata = nx.wdata;
        #1;
        n_cmp++;
        if (gnt !== 1'b0) begin n_err++; $display("FAIL gnt_during_resp c%0d: got %b expected 0", c, gnt); end
      end
    end
    pready = 1'b0;
    $display("txn %s addr=%h be=%h wdata=%h waits=%0d slverr=%0d -> rvalid@c%0d err=%0d rdata=%h",
             t.we ? "WR" : "RD", t.addr, t.be, t.wdata, t.waits, t.slverr, r, e_err, e_rdata);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({gnt, psel, penable, pwrite, rvalid, err} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 000000", {gnt, psel, penable, pwrite, rvalid, err});
    end
    n_cmp++;
    if ({paddr, pwdata, pstrb, rdata} !== 100'b0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", paddr, pwdata, pstrb, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    txn_t dummy;
    dummy = mk(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0);
    do_txn(mk(32'h0600_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, 32'h0), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h0600_0104, 1'b0, 4'hF, 32'h0, 2, 1'b0, 32'h1234_5678), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h0800_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hFFFF_FFFF), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h05FF_FFFF, 1'b1, 4'h3, 32'h1111_2222, 0, 1'b0, 32'h0), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h0600_0000, 1'b0, 4'h1, 32'h0, 1, 1'b0, 32'hA5A5_5A5A), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h07FF_FFFF, 1'b1, 4'hC, 32'hCAFE_F00D, 0, 1'b0, 32'h0), 1'b0, 1'b0, dummy);
  endtask

  task automatic test_timeout();
    txn_t dummy;
    dummy = mk(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0);
    do_txn(mk(32'h0600_0200, 1'b0, 4'hF, 32'h0, TO + 5, 1'b0, 32'h7777_7777), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h0600_0204, 1'b0, 4'hF, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE), 1'b0, 1'b0, dummy);
    do_txn(mk(32'h0600_0208, 1'b1, 4'h5, 32'h5555_AAAA, TO, 1'b0, 32'h0), 1'b0, 1'b0, dummy);
  endtask

  task automatic test_back_to_back();
    txn_t wr, rd, dummy;
    dummy = mk(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0);
    wr = mk(32'h0600_0040, 1'b1, 4'hF, 32'h0102_0304, 0, 1'b1, 32'h0);
    rd = mk(32'h0600_0044, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h8765_4321);
    do_txn(wr, 1'b0, 1'b1, rd);
    do_txn(rd, 1'b1, 1'b0, dummy);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; addr = 32'h0600_0300; we = 1'b1; be = 4'hF; wdata = 32'h1357_9BDF;
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid_gnt: got %b expected 1", gnt); end
    @(negedge clk); req = 1'b0; pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({psel, penable} !== 2'b11) begin n_err++; $display("FAIL rst_mid_access: got %b expected 11", {psel, penable}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({psel, penable, rvalid, err} !== 4'b0) begin
      n_err++; $display("FAIL rst_mid_async: got %b expected 0000", {psel, penable, rvalid, err});
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; pready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({psel, rvalid} !== 2'b0) begin n_err++; $display("FAIL rst_mid_quiet c%0d: got %b expected 00", c, {psel, rvalid}); end
    end
    pready = 1'b0;
    $display("txn WR addr=06000300 aborted by reset in ACCESS");
    do_txn(mk(32'h0600_0310, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'h2468_ACE0), 1'b0, 1'b0,
           mk(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0));
  endtask

  task automatic test_random();
    txn_t cur, nx;
    bit chained, ch;
    chained = 1'b0;
    cur = rand_txn();
    for (int i = 0; i < 150; i++) begin
      nx = rand_txn();
      ch = ($urandom_range(0, 2) == 0) && (i < 149);
      do_txn(cur, chained, ch, nx);
      chained = ch;
      cur = nx;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
